// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU memory arbiter and the pipeline stages that
// drive it (cpu_id/cpu_mem reuse the dm_drw encoding below).
//  state_t      : arbiter FSM states with fixed encodings
//  DRW_*        : data-request encoding on dm_drw, bit 1 = read, bit 0 = write
//  TIMEOUT_W    : width of the bus timeout counter
package cpu_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StArb     = 2'd0,
    StData    = 2'd1,
    StFetch   = 2'd2,
    StRelease = 2'd3
  } state_t;

  localparam logic [1:0] DRW_NONE    = 2'b00;
  localparam logic [1:0] DRW_WRITE   = 2'b01;
  localparam logic [1:0] DRW_READ    = 2'b10;
  localparam logic [1:0] DRW_ILLEGAL = 2'b11;

  localparam int unsigned TIMEOUT_W = 8;

endpackage

// File: rtl/cpu_mem_arbiter_bus_timeout_ctr.sv
// Bus wait counter for the memory arbiter.
//  clk, rst : clock, synchronous active-high reset
//  clr      : restart the count at zero (entry to a wait state)
//  inc      : one more cycle spent without bus_ack
//  tc       : the current wait cycle is the TIMEOUT-th one without ack
module cpu_mem_arbiter_bus_timeout_ctr
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  // Count holds the number of ack-less cycles already completed, so the
  // TIMEOUT-th ack-less cycle is the one where the count equals TIMEOUT-1.
  localparam logic [TIMEOUT_W-1:0] TermCount = TIMEOUT_W'(TIMEOUT - 1);

  logic [TIMEOUT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_q <= '0;
    end else if (inc) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign tc = (count_q == TermCount);

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shared memory bus arbiter between instruction fetch and data access.
// One CPU step: optional data access, then one fetch, then a single release
// cycle where cpu_stall drops and the pipeline advances.
//  clk, rst              : clock, synchronous active-high reset
//  if_addr / if_rdata    : fetch address in, fetched instruction out
//  dm_drw/dm_addr/dm_wdata : data request from MEM ([1]=read, [0]=write)
//  dm_rdata              : load result
//  bus_addr/bus_wdata/bus_rd/bus_wr : registered bus request
//  bus_ack/bus_rdata     : bus completion pulse and read data
//  cpu_stall             : pipeline freeze, low only in the release cycle
//  bus_err               : one-cycle pulse on timeout or illegal dm_drw
module cpu_mem_arbiter
  import cpu_mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  input  logic [1:0]  dm_drw,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        cpu_stall,
  output logic        bus_err
);

  state_t      state_q;
  logic [31:0] if_addr_q;
  logic        dm_read_q;

  logic waiting;
  logic tc;
  logic done;
  logic timed_out;
  logic ctr_clr;
  logic ctr_inc;

  assign waiting   = (state_q == StData) || (state_q == StFetch);
  // An ack in the terminal cycle takes priority over the timeout.
  assign done      = waiting && (bus_ack || tc);
  assign timed_out = waiting && !bus_ack && tc;
  assign ctr_clr   = !waiting || ((state_q == StData) && done);
  assign ctr_inc   = waiting && !bus_ack;

  cpu_mem_arbiter_bus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .inc (ctr_inc),
    .tc  (tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StArb;
      if_addr_q <= '0;
      dm_read_q <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_rd    <= 1'b0;
      bus_wr    <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      unique case (state_q)
        StArb: begin
          // Latched so the fetch after a data access uses this step's pc.
          if_addr_q <= if_addr;
          if (dm_drw != DRW_NONE) begin
            bus_addr  <= dm_addr;
            bus_wdata <= dm_wdata;
            bus_rd    <= (dm_drw == DRW_READ);
            bus_wr    <= (dm_drw != DRW_READ);
            dm_read_q <= (dm_drw == DRW_READ);
            state_q   <= StData;
          end else begin
            bus_addr <= if_addr;
            bus_rd   <= 1'b1;
            state_q  <= StFetch;
          end
        end
        StData: begin
          if (done) begin
            if (dm_read_q) begin
              dm_rdata <= bus_ack ? bus_rdata : '0;
            end
            // Go straight from the data strobe to the fetch strobe.
            bus_wr   <= 1'b0;
            bus_rd   <= 1'b1;
            bus_addr <= if_addr_q;
            state_q  <= StFetch;
          end
        end
        StFetch: begin
          if (done) begin
            bus_rd   <= 1'b0;
            if_rdata <= bus_ack ? bus_rdata : '0;
            state_q  <= StRelease;
          end
        end
        StRelease: begin
          bus_rd  <= 1'b0;
          bus_wr  <= 1'b0;
          state_q <= StArb;
        end
      endcase
    end
  end

  assign cpu_stall = (state_q != StRelease) && !rst;
  assign bus_err   = !rst && (((state_q == StArb) && (dm_drw == DRW_ILLEGAL)) || timed_out);

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter. Each CPU step is expanded into a
// per-cycle timeline (ARB, data wait cycles, fetch wait cycles, release) from
// the request and ack delays; a single compare process checks the DUT against
// that timeline every cycle, and literal expectations pin key results.
module tb_cpu_mem_arbiter;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic [1:0]  dm_drw = 2'b00;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic [31:0] dm_rdata;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        cpu_stall;
  logic        bus_err;

  cpu_mem_arbiter #(
    .TIMEOUT (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .dm_drw    (dm_drw),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_ack   (bus_ack),
    .bus_rdata (bus_rdata),
    .cpu_stall (cpu_stall),
    .bus_err   (bus_err)
  );

  always #5 clk = ~clk;

  // One cycle of the expected timeline plus the bus inputs to drive in it.
  typedef struct packed {
    logic        ack;
    logic [31:0] rdata;
    logic [31:0] in_if;
    logic        stall;
    logic        rd;
    logic        wr;
    logic        err;
    logic        chk_addr;
    logic [31:0] addr;
    logic        chk_wd;
    logic [31:0] wdata;
    logic        chk_res;
    logic [31:0] if_rd;
    logic [31:0] dm_rd;
  } cyc_t;

  cyc_t recs[$];
  cyc_t cur;
  bit   cur_valid = 1'b0;

  int checks = 0;
  int errors = 0;
  int step_cycles, rel_at, rd_cycles, err_cycles;

  logic [31:0] exp_if = '0;
  logic [31:0] exp_dm = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the timeline.
  always @(negedge clk) begin
    if (cur_valid) begin
      chk("cpu_stall", 32'(cpu_stall), 32'(cur.stall));
      chk("bus_rd", 32'(bus_rd), 32'(cur.rd));
      chk("bus_wr", 32'(bus_wr), 32'(cur.wr));
      chk("bus_err", 32'(bus_err), 32'(cur.err));
      if (cur.chk_addr) chk("bus_addr", bus_addr, cur.addr);
      if (cur.chk_wd) chk("bus_wdata", bus_wdata, cur.wdata);
      if (cur.chk_res) begin
        chk("if_rdata", if_rdata, cur.if_rd);
        chk("dm_rdata", dm_rdata, cur.dm_rd);
      end
      step_cycles++;
      if (!cpu_stall && rel_at == 0) rel_at = step_cycles;
      if (bus_rd) rd_cycles++;
      if (bus_err) err_cycles++;
    end
  end

  // Append one bus access phase: ack arrives in cycle 'delay' of the strobe,
  // or never (delay 0), in which case the access times out after TO cycles.
  task automatic add_phase(input int delay, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           output logic [31:0] result);
    cyc_t r;
    bit   to;
    int   n;
    to = (delay == 0);
    n  = to ? int'(TO) : delay;
    for (int i = 1; i <= n; i++) begin
      r          = '0;
      r.in_if    = 32'hBAD0_0000 ^ 32'(i);
      r.stall    = 1'b1;
      r.rd       = rd;
      r.wr       = !rd;
      r.ack      = !to && (i == n);
      r.rdata    = rdata;
      r.err      = to && (i == n);
      r.chk_addr = 1'b1;
      r.addr     = addr;
      r.chk_wd   = !rd;
      r.wdata    = wdata;
      recs.push_back(r);
    end
    result = to ? 32'h0 : rdata;
  endtask

  task automatic run_step(input logic [1:0] drw, input logic [31:0] daddr,
                          input logic [31:0] wdata, input logic [31:0] iaddr,
                          input int dd, input int fd, input logic [31:0] drd,
                          input logic [31:0] frd, input logic stray);
    cyc_t        r;
    logic [31:0] res;
    recs.delete();
    r       = '0;
    r.ack   = stray;
    r.rdata = 32'hFFFF_FFFF;
    r.in_if = iaddr;
    r.stall = 1'b1;
    r.err   = (drw == 2'b11);
    recs.push_back(r);
    if (drw != 2'b00) begin
      add_phase(dd, (drw == 2'b10), daddr, wdata, drd, res);
      if (drw == 2'b10) exp_dm = res;
    end
    add_phase(fd, 1'b1, iaddr, 32'h0, frd, res);
    exp_if    = res;
    r         = '0;
    r.in_if   = 32'hBAD1_0000;
    r.chk_res = 1'b1;
    r.if_rd   = exp_if;
    r.dm_rd   = exp_dm;
    recs.push_back(r);

    dm_drw      = drw;
    dm_addr     = daddr;
    dm_wdata    = wdata;
    step_cycles = 0;
    rel_at      = 0;
    rd_cycles   = 0;
    err_cycles  = 0;
    foreach (recs[k]) begin
      bus_ack   = recs[k].ack;
      bus_rdata = recs[k].rdata;
      if_addr   = recs[k].in_if;
      cur       = recs[k];
      cur_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    cur_valid = 1'b0;
    bus_ack   = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", 32'(cpu_stall), 32'h0);
    chk("rst_bus_rd", 32'(bus_rd), 32'h0);
    chk("rst_bus_wr", 32'(bus_wr), 32'h0);
    chk("rst_bus_err", 32'(bus_err), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    rst = 1'b0;

    // 1: fetch only, ack in first strobe cycle
    run_step(2'b00, 32'h0, 32'h0, 32'h100, 0, 1, 32'h0, 32'h2402_000A, 1'b0);
    chk("t1_release_cycle", 32'(rel_at), 32'd3);
    chk("t1_rd_cycles", 32'(rd_cycles), 32'd1);
    chk("t1_if_rdata", if_rdata, 32'h2402_000A);

    // 2: load then fetch
    run_step(2'b10, 32'h1000, 32'h0, 32'h104, 1, 1, 32'hDEAD_BEEF, 32'hABCD_0000, 1'b0);
    chk("t2_release_cycle", 32'(rel_at), 32'd4);
    chk("t2_dm_rdata", dm_rdata, 32'hDEAD_BEEF);
    chk("t2_if_rdata", if_rdata, 32'hABCD_0000);

    // 3: store with 3-cycle ack delay on both accesses; load data survives
    run_step(2'b01, 32'h2000, 32'h55AA_55AA, 32'h108, 3, 3, 32'h1111_1111, 32'h2222_2222,
             1'b0);
    chk("t3_release_cycle", 32'(rel_at), 32'd8);
    chk("t3_dm_rdata_kept", dm_rdata, 32'hDEAD_BEEF);

    // 4: fetch never acked -> timeout
    run_step(2'b00, 32'h0, 32'h0, 32'h10C, 0, 0, 32'h0, 32'h0, 1'b0);
    chk("t4_release_cycle", 32'(rel_at), 32'd6);
    chk("t4_err_cycles", 32'(err_cycles), 32'd1);
    chk("t4_if_rdata", if_rdata, 32'h0);

    // 4b: stray ack in ARB is ignored
    run_step(2'b00, 32'h0, 32'h0, 32'h110, 0, 2, 32'h0, 32'h3333_3333, 1'b1);
    chk("t4b_release_cycle", 32'(rel_at), 32'd4);
    chk("t4b_err_cycles", 32'(err_cycles), 32'd0);

    // 5: illegal request behaves as a write and flags an error in ARB
    run_step(2'b11, 32'h3000, 32'hCAFE_F00D, 32'h114, 1, 1, 32'h0, 32'h4444_4444, 1'b0);
    chk("t5_err_cycles", 32'(err_cycles), 32'd1);
    chk("t5_release_cycle", 32'(rel_at), 32'd4);

    // 7: ack on the terminal count wins; then a load that times out
    run_step(2'b10, 32'h3004, 32'h0, 32'h118, 4, 1, 32'h5A5A_5A5A, 32'h6666_6666, 1'b0);
    chk("t7_err_cycles", 32'(err_cycles), 32'd0);
    chk("t7_release_cycle", 32'(rel_at), 32'd7);
    chk("t7_dm_rdata", dm_rdata, 32'h5A5A_5A5A);
    run_step(2'b10, 32'h3008, 32'h0, 32'h11C, 0, 1, 32'h7777_7777, 32'h8888_8888, 1'b0);
    chk("t7b_dm_rdata", dm_rdata, 32'h0);

    // 6: reset while a data access is outstanding
    dm_drw  = 2'b10;
    dm_addr = 32'h4000;
    if_addr = 32'h500;
    bus_ack = 1'b0;
    @(posedge clk);
    #1;
    chk("t6_data_rd", 32'(bus_rd), 32'h1);
    chk("t6_data_addr", bus_addr, 32'h4000);
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", 32'(cpu_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("t6_rst_bus_rd", 32'(bus_rd), 32'h0);
    chk("t6_rst_bus_wr", 32'(bus_wr), 32'h0);
    chk("t6_rst_dm_rdata", dm_rdata, 32'h0);
    exp_if = 32'h0;
    exp_dm = 32'h0;
    rst    = 1'b0;
    run_step(2'b00, 32'h0, 32'h0, 32'h600, 0, 1, 32'h0, 32'h9999_9999, 1'b0);
    chk("t6_release_cycle", 32'(rel_at), 32'd3);
    chk("t6_if_rdata", if_rdata, 32'h9999_9999);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
